// File: rtl/mem_port_arbiter.sv
// N-port arbiter onto the single memory controller port: round-robin or fixed priority,
// requests latched at grant, 4-phase release. Optional read timeout under MEM_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no owner, arbitrating among active ports
// ISSUE   | winner latched, waiting for memory ready to strobe the command
// WAIT_RD | read strobed, waiting for memory read data (or timeout)
// RELEASE | completion signalled, holding grant until the winner drops its request
module mem_port_arbiter #(
    parameter int NUM_PORTS      = 3,
    parameter int ADDR_W         = 26,
    parameter int DATA_W         = 32,
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_rd,
    input  logic [NUM_PORTS-1:0]        req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*2-1:0]      req_width,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wr_data,
    output logic [NUM_PORTS-1:0]        rsp_rd_valid,
    output logic [NUM_PORTS-1:0]        rsp_wr_done,
    output logic [NUM_PORTS-1:0]        rsp_rd_err,
    output logic [DATA_W-1:0]           rsp_rd_data,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        mem_rd,
    output logic                        mem_wr,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [1:0]                  mem_data_width,
    output logic [DATA_W-1:0]           mem_wr_data,
    input  logic                        mem_rd_ready,
    input  logic                        mem_wr_ready,
    input  logic                        mem_rd_valid,
    input  logic [DATA_W-1:0]           mem_rd_data
);

    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RELEASE} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  op_rd_q, op_rd_d;
    logic [NUM_PORTS-1:0]  grant_q, grant_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [1:0]            mem_width_q, mem_width_d;
    logic [DATA_W-1:0]     mem_wr_data_q, mem_wr_data_d;
    logic [NUM_PORTS-1:0]  rsp_rd_valid_q, rsp_rd_valid_d;
    logic [NUM_PORTS-1:0]  rsp_wr_done_q, rsp_wr_done_d;
    logic [DATA_W-1:0]     rsp_rd_data_q, rsp_rd_data_d;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]  rsp_rd_err_q, rsp_rd_err_d;
`endif

    logic [NUM_PORTS-1:0]  active;
    logic                  win_found;
    logic [PW-1:0]         win_idx;
    logic [PW-1:0]         idx;

    assign active = req_rd | req_wr;

    // Search starts just past the last winner in round-robin mode, at port 0 otherwise.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (RR_MODE != 0) idx = PW'((int'(ptr_q) + k) % NUM_PORTS);
            else              idx = PW'(k - 1);
            if (!win_found && active[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        op_rd_d        = op_rd_q;
        grant_d        = grant_q;
        mem_addr_d     = mem_addr_q;
        mem_width_d    = mem_width_q;
        mem_wr_data_d  = mem_wr_data_q;
        rsp_rd_data_d  = rsp_rd_data_q;
        mem_rd_d       = 1'b0;
        mem_wr_d       = 1'b0;
        rsp_rd_valid_d = '0;
        rsp_wr_done_d  = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d          = cnt_q;
        rsp_rd_err_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    mem_addr_d    = req_addr[win_idx*ADDR_W +: ADDR_W];
                    mem_width_d   = req_width[win_idx*2 +: 2];
                    mem_wr_data_d = req_wr_data[win_idx*DATA_W +: DATA_W];
                    grant_d       = NUM_PORTS'(1) << win_idx;
                    op_rd_d       = req_rd[win_idx];
                    ptr_d         = win_idx;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (op_rd_q) begin
                    if (mem_rd_ready) begin
                        mem_rd_d = 1'b1;
                        state_d  = WAIT_RD;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end
                end else if (mem_wr_ready) begin
                    mem_wr_d      = 1'b1;
                    rsp_wr_done_d = grant_q;
                    state_d       = RELEASE;
                end
            end
            WAIT_RD: begin
                if (mem_rd_valid) begin
                    rsp_rd_data_d  = mem_rd_data;
                    rsp_rd_valid_d = grant_q;
                    state_d        = RELEASE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rd_data_d  = '1;
                    rsp_rd_valid_d = grant_q;
                    rsp_rd_err_d   = grant_q;
                    state_d        = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if ((grant_q & active) == '0) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            ptr_q          <= PW'(NUM_PORTS - 1);
            op_rd_q        <= 1'b0;
            grant_q        <= '0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_width_q    <= '0;
            mem_wr_data_q  <= '0;
            rsp_rd_valid_q <= '0;
            rsp_wr_done_q  <= '0;
            rsp_rd_data_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q          <= '0;
            rsp_rd_err_q   <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            op_rd_q        <= op_rd_d;
            grant_q        <= grant_d;
            mem_rd_q       <= mem_rd_d;
            mem_wr_q       <= mem_wr_d;
            mem_addr_q     <= mem_addr_d;
            mem_width_q    <= mem_width_d;
            mem_wr_data_q  <= mem_wr_data_d;
            rsp_rd_valid_q <= rsp_rd_valid_d;
            rsp_wr_done_q  <= rsp_wr_done_d;
            rsp_rd_data_q  <= rsp_rd_data_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q          <= cnt_d;
            rsp_rd_err_q   <= rsp_rd_err_d;
`endif
        end
    end

    assign grant          = grant_q;
    assign mem_rd         = mem_rd_q;
    assign mem_wr         = mem_wr_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data_width = mem_width_q;
    assign mem_wr_data    = mem_wr_data_q;
    assign rsp_rd_valid   = rsp_rd_valid_q;
    assign rsp_wr_done    = rsp_wr_done_q;
    assign rsp_rd_data    = rsp_rd_data_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign rsp_rd_err     = rsp_rd_err_q;
`else
    assign rsp_rd_err     = '0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-port arbiter between requesters (cart bus, USB FIFO, future DMA engines) and the single memory controller port. It generalises the two-source cart/USB mux: any number of ports, configurable data/address width, round-robin or fixed-priority mode, and per-port completion and error signalling. Requests are latched at grant, so a requester's address and data need only be stable until completion.

## Interface
Parameters:
- NUM_PORTS, 3: number of requester ports (2..8).
- ADDR_W, 26: address width.
- DATA_W, 32: data width (16 or 32).
- RR_MODE, 1: 1 = round-robin; 0 = fixed priority, port 0 highest.
- TIMEOUT_CYCLES, 1024: read timeout, used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-low reset; rst = 0 at a rising edge resets the block.
- req_rd  in  NUM_PORTS  per-port read request, level.
- req_wr  in  NUM_PORTS  per-port write request, level.
- req_addr  in  NUM_PORTS*ADDR_W  per-port address; port i is at [i*ADDR_W +: ADDR_W].
- req_width  in  NUM_PORTS*2  per-port width code: 00 = none, 01 = 8-bit, 10 = 16-bit, 11 = 32-bit.
- req_wr_data  in  NUM_PORTS*DATA_W  per-port write data.
- rsp_rd_valid  out  NUM_PORTS  one-hot, one-cycle read completion.
- rsp_wr_done  out  NUM_PORTS  one-hot, one-cycle write completion.
- rsp_rd_err  out  NUM_PORTS  one-hot, one-cycle timeout flag, coincident with rsp_rd_valid.
- rsp_rd_data  out  DATA_W  shared read data; valid when any rsp_rd_valid bit is set.
- grant  out  NUM_PORTS  one-hot owner of the current transaction; 0 in IDLE.
- mem_rd, mem_wr  out  1  one-cycle command strobes.
- mem_addr  out  ADDR_W  latched address.
- mem_data_width  out  2  latched width code.
- mem_wr_data  out  DATA_W  latched write data.
- mem_rd_ready, mem_wr_ready  in  1  memory can accept a read or write command.
- mem_rd_valid  in  1  memory read data valid.
- mem_rd_data  in  DATA_W  memory read data.

## Operation
- All outputs are registered.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - round-robin pointer = NUM_PORTS-1, so port 0 wins first.
- A reset mid-transaction aborts the transaction, drops any strobe in the same cycle, and issues no completion.
- States: IDLE, ISSUE, WAIT_RD, RELEASE.
- IDLE:
  - A port is active if req_rd or req_wr is set.
  - Winner: RR_MODE = 1 searches from pointer+1 upward with wrap-around; RR_MODE = 0 takes the lowest-index active port.
  - On a winner: latch its addr, width and wr_data into the mem_* registers; set grant; latch the op (read wins if both req_rd and req_wr are set); go to ISSUE.
  - The pointer is updated to the winner at grant.
  - With no active port, stay in IDLE.
- ISSUE:
  - Read: when mem_rd_ready = 1, pulse mem_rd and go to WAIT_RD.
  - Write: when mem_wr_ready = 1, pulse mem_wr, pulse rsp_wr_done[winner] in the same cycle, and go to RELEASE.
  - Otherwise stay in ISSUE with no strobe.
- WAIT_RD: when mem_rd_valid = 1, capture mem_rd_data into rsp_rd_data, pulse rsp_rd_valid[winner], and go to RELEASE.
- RELEASE:
  - Holds grant until the winner's req_rd and req_wr are both 0 (4-phase handshake), then returns to IDLE.
  - Requests from other ports are held pending, not lost.
- rsp_rd_data holds its value until the next read completion.
- mem_addr, mem_data_width and mem_wr_data hold their values after a transaction and are cleared only by reset.
- Requester changes to addr/data after grant have no effect.

## Timing
- Request seen at edge E0 in IDLE → grant and mem_* latched at E0 → strobe at E1 at the earliest.
- Write: strobe and rsp_wr_done coincide, 2 cycles after the request.
- Read: rsp_rd_valid one edge after the mem_rd_valid sample, so minimum read latency is strobe + memory latency + 1.
- Strobes are exactly one cycle wide and never overlap.
- Minimum back-to-back spacing between two ports: RELEASE exit + 1 edge in IDLE.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_RD and increments each cycle in WAIT_RD.
  - If it reaches TIMEOUT_CYCLES with no mem_rd_valid, the read aborts: rsp_rd_data = all ones, rsp_rd_valid[winner] and rsp_rd_err[winner] pulse together, then go to RELEASE.
  - If mem_rd_valid arrives on the expiry cycle, the valid data wins and no error is raised.
- MEM_ARB_TIMEOUT_EN not defined:
  - WAIT_RD waits indefinitely.
  - rsp_rd_err is tied to 0 and no counter logic exists.

## Test plan
- Reset: hold rst = 0 during a WAIT_RD, release → all outputs 0, grant = 0, the pending read on port 1 re-arbitrates and completes normally.
- Single read: port 0 reads addr 0x0000100, memory returns 0xDEADBEEF 3 cycles after mem_rd → rsp_rd_valid = 3'b001 with rsp_rd_data = 0xDEADBEEF, exactly one mem_rd pulse.
- Round-robin: all 3 ports hold continuous writes (RR_MODE = 1) → grant order 0, 1, 2, 0, each port gets one rsp_wr_done per round; with RR_MODE = 0 port 0 wins every round.
- Backpressure: mem_wr_ready = 0 for 5 cycles during port 2's write of 0x12345678 → no mem_wr for 5 cycles, then one mem_wr with mem_wr_data = 0x12345678; a change to req_wr_data after grant is ignored.
- 4-phase: port 1 holds req_rd 4 cycles after rsp_rd_valid → grant stays 3'b010 and no second mem_rd is issued until req_rd drops.
- Timeout (with MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16): mem_rd_valid never arrives → after 16 cycles, rsp_rd_err = rsp_rd_valid = 3'b001 and rsp_rd_data = 0xFFFFFFFF.
